// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: fixed-latency mult/div sequencing with the
// HI/LO register pair and pipeline stall request.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    localparam int unsigned DW = 32,
    localparam int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [2:0]    md_op,
    input  logic [DW-1:0] md_a,
    input  logic [DW-1:0] md_b,
    output logic          busy,
    output logic          stall_req,
    output logic [DW-1:0] hi,
    output logic [DW-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic            sgn_q, sgn_d;
    logic [DW-1:0]   hi_q, hi_d;
    logic [DW-1:0]   lo_q, lo_d;
    logic            busy_q, busy_d;

    logic [2*DW-1:0] a_ext, b_ext, prod;
    logic            a_neg, b_neg, b_zero;
    logic [DW-1:0]   a_mag, b_mag, b_div;
    logic [DW-1:0]   q_mag, r_mag, quot, rem;

    // Operands sign/zero-extended to 64 bits so one multiplier serves mult and multu
    always_comb begin
        a_ext = {{DW{sgn_q & a_q[DW-1]}}, a_q};
        b_ext = {{DW{sgn_q & b_q[DW-1]}}, b_q};
        prod  = a_ext * b_ext;
    end

    // Signed division on magnitudes: quotient truncates toward zero, remainder follows dividend
    always_comb begin
        a_neg  = sgn_q & a_q[DW-1];
        b_neg  = sgn_q & b_q[DW-1];
        a_mag  = a_neg ? (~a_q + DW'(1)) : a_q;
        b_mag  = b_neg ? (~b_q + DW'(1)) : b_q;
        b_zero = (b_q == '0);
        b_div  = b_zero ? DW'(1) : b_mag;
        q_mag  = a_mag / b_div;
        r_mag  = a_mag % b_div;
        quot   = (a_neg ^ b_neg) ? (~q_mag + DW'(1)) : q_mag;
        rem    = a_neg ? (~r_mag + DW'(1)) : r_mag;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    unique case (md_op)
                        3'b000, 3'b001: begin
                            state_d = S_MUL;
                            cnt_d   = CW'(MULT_CYCLES - 1);
                            a_d     = md_a;
                            b_d     = md_b;
                            sgn_d   = ~md_op[0];
                        end
                        3'b010, 3'b011: begin
                            state_d = S_DIV;
                            cnt_d   = CW'(DIV_CYCLES - 1);
                            a_d     = md_a;
                            b_d     = md_b;
                            sgn_d   = ~md_op[0];
                        end
                        3'b100:  hi_d = md_a;
                        3'b101:  lo_d = md_a;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (cnt_q == '0) begin
                    hi_d    = prod[2*DW-1:DW];
                    lo_d    = prod[DW-1:0];
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DIV: begin
                if (cnt_q == '0) begin
                    // Divide by zero keeps the full latency but commits nothing
                    if (!b_zero) begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    // Raised in the issue cycle itself so a dependent mfhi/mflo stalls without a gap
    assign stall_req = busy_q | (start & ~md_op[2]);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios plus randomized ops
// against a plain-arithmetic HI/LO reference model.
module tb_mdu_ctrl;

    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks;
    int          n_fail;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mdu_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .md_op     (md_op),
        .md_a      (md_a),
        .md_b      (md_b),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural effect of one accepted op on HI/LO
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l, output logic wr);
        longint          sa;
        longint          sb;
        longint          sp;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        h  = exp_hi;
        l  = exp_lo;
        wr = 1'b1;
        case (op)
            3'b000: begin sp = sa * sb; {h, l} = sp; end
            3'b001: begin up = ua * ub; {h, l} = up; end
            3'b010: begin
                if (b == 32'h0) wr = 1'b0;
                else begin l = 32'(sa / sb); h = 32'(sa % sb); end
            end
            3'b011: begin
                if (b == 32'h0) wr = 1'b0;
                else begin l = 32'(ua / ub); h = 32'(ua % ub); end
            end
            3'b100:  h = a;
            3'b101:  l = a;
            default: wr = 1'b0;
        endcase
    endfunction

    // Issue a mult/div, check busy/hold for its full latency, optional colliding start at busy cycle col_k
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int col_k, input logic [2:0] col_op);
        int unsigned n;
        logic [31:0] nh;
        logic [31:0] nl;
        logic        wr;
        model(op, a, b, nh, nl, wr);
        n = op[1] ? DIV_N : MULT_N;
        start = 1'b1;
        md_op = op;
        md_a  = a;
        md_b  = b;
        #1;
        chk1("issue_stall", stall_req, 1'b1);
        step();
        for (int k = 0; k < int'(n); k++) begin
            chk1("busy_high", busy, 1'b1);
            chk1("stall_busy", stall_req, 1'b1);
            chk("hi_hold", hi, exp_hi);
            chk("lo_hold", lo, exp_lo);
            md_a  = $urandom;
            md_b  = $urandom;
            start = (k == col_k);
            md_op = col_op;
            step();
        end
        start = 1'b0;
        if (wr) begin
            exp_hi = nh;
            exp_lo = nl;
        end
        chk1("busy_done", busy, 1'b0);
        chk("hi_result", hi, exp_hi);
        chk("lo_result", lo, exp_lo);
    endtask

    // Single-cycle ops from IDLE: mthi, mtlo, no-ops
    task automatic run_simple(input logic [2:0] op, input logic [31:0] a);
        logic [31:0] nh;
        logic [31:0] nl;
        logic        wr;
        model(op, a, 32'h0, nh, nl, wr);
        start = 1'b1;
        md_op = op;
        md_a  = a;
        md_b  = $urandom;
        #1;
        chk1("simple_stall", stall_req, 1'b0);
        step();
        start = 1'b0;
        if (wr) begin
            exp_hi = nh;
            exp_lo = nl;
        end
        chk1("simple_busy", busy, 1'b0);
        chk("simple_hi", hi, exp_hi);
        chk("simple_lo", lo, exp_lo);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [2:0]  cop;
        logic [31:0] ra;
        logic [31:0] rb;
        n_checks = 0;
        n_fail   = 0;
        exp_hi   = 32'h0;
        exp_lo   = 32'h0;
        reset_n  = 1'b0;
        start    = 1'b0;
        md_op    = 3'b000;
        md_a     = 32'h0;
        md_b     = 32'h0;

        step();
        step();
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_stall", stall_req, 1'b0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        reset_n = 1'b1;

        // First start right after release is accepted on the first edge
        run_md(3'b000, 32'hFFFF_FFFF, 32'h2, -1, 3'b000);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFE);

        run_md(3'b001, 32'hFFFF_FFFF, 32'h2, -1, 3'b000);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        run_simple(3'b100, 32'h1234_5678);
        chk("mthi_hi", hi, 32'h1234_5678);
        run_simple(3'b101, 32'hA5A5_A5A5);
        chk("mtlo_lo", lo, 32'hA5A5_A5A5);

        run_md(3'b011, 32'd100, 32'd7, -1, 3'b000);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        run_md(3'b010, 32'hFFFF_FFF9, 32'h2, -1, 3'b000);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi, 32'hFFFF_FFFF);

        run_md(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, -1, 3'b000);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'h0);

        run_simple(3'b100, 32'hDEAD_BEEF);
        run_simple(3'b101, 32'hCAFE_F00D);
        run_md(3'b010, 32'h1234_5678, 32'h0, -1, 3'b000);
        chk("div0_hi", hi, 32'hDEAD_BEEF);
        chk("div0_lo", lo, 32'hCAFE_F00D);

        // Collisions: mtlo mid-busy, then mult and mthi on the completion edge
        run_md(3'b000, 32'h0000_1234, 32'hFFFF_0003, 2, 3'b101);
        run_md(3'b011, 32'hFFFF_FFFF, 32'h0000_0010, int'(DIV_N) - 1, 3'b000);
        run_md(3'b001, 32'h8765_4321, 32'h1357_9BDF, int'(MULT_N) - 1, 3'b100);

        run_simple(3'b110, 32'h5555_5555);
        run_simple(3'b111, 32'h6666_6666);

        // Asynchronous reset in the middle of a mult
        run_simple(3'b100, 32'h1111_1111);
        start = 1'b1;
        md_op = 3'b000;
        md_a  = 32'h0000_0003;
        md_b  = 32'h0000_0005;
        step();
        start = 1'b0;
        step();
        step();
        chk1("pre_rst_busy", busy, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        exp_hi = 32'h0;
        exp_lo = 32'h0;
        chk1("arst_busy", busy, 1'b0);
        chk("arst_hi", hi, 32'h0);
        chk("arst_lo", lo, 32'h0);
        step();
        step();
        #2;
        reset_n = 1'b1;
        for (int k = 0; k < int'(MULT_N) + 2; k++) begin
            step();
            chk1("post_rst_busy", busy, 1'b0);
            chk("post_rst_hi", hi, 32'h0);
            chk("post_rst_lo", lo, 32'h0);
        end
        run_md(3'b000, 32'h0000_0003, 32'h0000_0005, -1, 3'b000);
        chk("post_rst_mult_lo", lo, 32'd15);

        // Randomized ops, with occasional zero divisors and stray starts while busy
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            cop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 5) == 0) rb = 32'h0;
            else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            if (rop <= 3'b011) run_md(rop, ra, rb, int'($urandom_range(0, 12)), cop);
            else run_simple(rop, ra);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, meaning busy cycles for mult/multu, range 1..15.
REQ-002 Parameter DIV_CYCLES, default 10, meaning busy cycles for div/divu, range 1..15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  issue strobe for md_op, sampled on the rising edge.
REQ-006 md_op  input  3  operation code:
  - 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo.
  - 110 and 111 are no-ops.
REQ-007 md_a  input  32  rs operand (dividend/multiplicand; mthi/mtlo source).
REQ-008 md_b  input  32  rt operand (divisor/multiplier).
REQ-009 busy  output  1  operation in progress, registered.
REQ-010 stall_req  output  1  combinational: busy OR (start AND md_op in {000..011}).
REQ-011 hi  output  32  HI register, registered.
REQ-012 lo  output  32  LO register, registered.

Function
REQ-013 The block SHALL implement three states:
  - IDLE: busy=0.
  - MUL: busy=1.
  - DIV: busy=1.
REQ-014 Issue from IDLE:
  - start=1 with md_op 000/001 SHALL capture operands, load the counter with MULT_CYCLES-1, and enter MUL at the next edge.
  - start=1 with md_op 010/011 SHALL do the same with DIV_CYCLES-1 and enter DIV.
REQ-015 In MUL/DIV the counter SHALL decrement once per cycle. On the edge where the counter is 0, the block SHALL:
  - write hi/lo,
  - return to IDLE,
  - deassert busy on that same edge.
  The result is therefore visible exactly N cycles after the issue edge, with busy high for exactly N cycles.
REQ-016 mult SHALL compute the signed 64-bit product and multu the unsigned 64-bit product: {hi,lo}=product.
REQ-017 div/divu SHALL write lo=quotient and hi=remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
REQ-018 Signed 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0.
REQ-019 Division with md_b=0 SHALL still occupy DIV for DIV_CYCLES, then leave hi and lo unchanged.
REQ-020 Results SHALL be computed from operands captured at issue; changes on md_a/md_b during busy SHALL have no effect.
REQ-021 mthi/mtlo with start=1 in IDLE SHALL write md_a into hi/lo respectively at the next edge, with busy staying 0 and no state change.
REQ-022 start=1 while busy=1 SHALL be ignored for all md_op values, including mthi/mtlo; the upstream pipeline guarantees it stalls on stall_req.
REQ-023 start=1 on the completion edge (busy=1, counter=0) SHALL be ignored; a new issue is accepted only from IDLE.
REQ-024 md_op 110/111 SHALL leave all state unchanged.
REQ-025 hi/lo SHALL only change on a completion edge or an mthi/mtlo write; reads are always allowed and show the last committed value during busy.
REQ-026 stall_req SHALL be 1 in the same cycle a mult/div start is presented, so a dependent mfhi/mflo in the next stage stalls without a bubble gap.

Reset
REQ-027 reset_n=0 SHALL immediately, without waiting for clk, force:
  - state=IDLE, counter=0,
  - busy=0,
  - hi=0, lo=0,
  - captured operands=0.
REQ-028 Reset asserted mid-operation SHALL abort the operation; no partial result is ever written to hi/lo.
REQ-029 After reset_n rises, the first start SHALL be accepted on the first rising edge at which reset_n=1.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
  - mult: start, mult, md_a=0xFFFFFFFF, md_b=2 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - multu and divu:
    - multu, same operands -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
    - divu 100/7 -> busy high 10 cycles; lo=14, hi=2.
  - div: div md_a=-7 (0xFFFFFFF9), md_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
    - div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
    - div by 0 -> busy 10 cycles, hi/lo unchanged.
  - mthi/mtlo and collisions:
    - mthi 0x12345678 in IDLE -> hi updates next edge, busy stays 0.
    - mtlo issued during busy -> lo unchanged.
    - start asserted on the completion edge -> ignored.
  - reset: reset_n pulsed low at busy cycle 3 of a mult -> busy, hi, lo drop to 0 immediately; no write follows; a new mult issued after release completes normally.
